// File: rtl/timebase_counter.sv
//-----------------------------------------------------------------------------
// timebase_counter
//
// Purpose:
//   Divides the free-running clk into a one-cycle tick strobe every DIV
//   cycles and uses each tick to advance a min:sec counter. A small
//   IDLE/RUN/PAUSE controller driven by start/stop/clear gates the counting.
//   Everything runs on clk; tick is a strobe, not a derived clock.
//
// Parameters:
//   DIV     - clk cycles per tick (DIV >= 2)
//   PW      - prescaler width (2**PW >= DIV)
//   SEC_MAX - last seconds value before wrap
//   MIN_MAX - last minutes value before wrap
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   start    in   level, enter or resume RUN
//   stop     in   level, enter PAUSE from RUN
//   clear    in   level, back to IDLE with all counters zeroed
//   tick     out  one-cycle strobe each prescaler wrap
//   sec      out  seconds count 0..SEC_MAX
//   min      out  minutes count 0..MIN_MAX
//   running  out  high while in RUN
//   wrap     out  one-cycle strobe on MIN_MAX:SEC_MAX -> 0:0
//
// Optional feature (macro TIMEBASE_LOAD_EN):
//   load     in   load sec/min while in IDLE or PAUSE
//   load_sec in   value for sec, saturated to SEC_MAX
//   load_min in   value for min, saturated to MIN_MAX
//-----------------------------------------------------------------------------
module timebase_counter #(
   parameter int DIV     = 50,
   parameter int PW      = 6,
   parameter int SEC_MAX = 59,
   parameter int MIN_MAX = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
`ifdef TIMEBASE_LOAD_EN
   input  logic       load,
   input  logic [5:0] load_sec,
   input  logic [5:0] load_min,
`endif
   output logic       tick,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic       running,
   output logic       wrap
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_presc;
   logic [5:0]      r_sec;
   logic [5:0]      r_min;
   logic            r_tick;
   logic            r_wrap;
   logic            r_running;

   // start only takes effect when stop is low (stop has priority).
   logic w_go;
   logic w_presc_last;
   logic w_sec_last;
   logic w_min_last;

   assign w_go         = start & ~stop;
   assign w_presc_last = (r_presc == PW'(DIV - 1));
   assign w_sec_last   = (r_sec == 6'(SEC_MAX));
   assign w_min_last   = (r_min == 6'(MIN_MAX));

`ifdef TIMEBASE_LOAD_EN
   logic       w_load_ok;
   logic [5:0] w_load_sec_sat;
   logic [5:0] w_load_min_sat;

   // Loading is only meaningful while the counter is not advancing.
   assign w_load_ok      = load & (r_state != ST_RUN);
   assign w_load_sec_sat = (load_sec > 6'(SEC_MAX)) ? 6'(SEC_MAX) : load_sec;
   assign w_load_min_sat = (load_min > 6'(MIN_MAX)) ? 6'(MIN_MAX) : load_min;
`endif

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_state   <= ST_IDLE;
         r_presc   <= '0;
         r_sec     <= '0;
         r_min     <= '0;
         r_tick    <= 1'b0;
         r_wrap    <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         r_wrap <= 1'b0;

         case (r_state)
            ST_IDLE, ST_PAUSE: begin
               // PAUSE keeps the prescaler phase so resume is seamless.
               if (w_go) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end else begin
                  r_running <= 1'b0;
               end
            end

            ST_RUN: begin
               if (stop) begin
                  // stop beats a pending prescaler wrap: the tick is
                  // deferred to the first RUN edge after resume.
                  r_state   <= ST_PAUSE;
                  r_running <= 1'b0;
               end else begin
                  r_running <= 1'b1;
                  if (w_presc_last) begin
                     r_presc <= '0;
                     r_tick  <= 1'b1;
                     if (w_sec_last) begin
                        r_sec <= '0;
                        if (w_min_last) begin
                           r_min  <= '0;
                           r_wrap <= 1'b1;
                        end else begin
                           r_min <= r_min + 6'd1;
                        end
                     end else begin
                        r_sec <= r_sec + 6'd1;
                     end
                  end else begin
                     r_presc <= r_presc + PW'(1);
                  end
               end
            end

            default: begin
               r_state   <= ST_IDLE;
               r_running <= 1'b0;
            end
         endcase

`ifdef TIMEBASE_LOAD_EN
         // Never collides with counting: counting only happens in RUN.
         if (w_load_ok) begin
            r_sec <= w_load_sec_sat;
            r_min <= w_load_min_sat;
         end
`endif
      end
   end

   assign tick    = r_tick;
   assign sec     = r_sec;
   assign min     = r_min;
   assign running = r_running;
   assign wrap    = r_wrap;

endmodule

// File: tb/tb_timebase_counter.sv
//-----------------------------------------------------------------------------
// tb_timebase_counter
//
// Scoreboard bench for timebase_counter with DIV=4. The stimulus process
// pushes the expected {edge, sec, min, wrap} for every tick it expects; the
// monitor pops one entry whenever tick is high and checks the edge number as
// well as the values, so latency and missing/extra ticks are caught.
//-----------------------------------------------------------------------------
module tb_timebase_counter;

   localparam int DIV     = 4;
   localparam int PW      = 2;
   localparam int SEC_MAX = 59;
`ifdef TIMEBASE_LOAD_EN
   localparam int MIN_MAX = 4;
`else
   localparam int MIN_MAX = 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       clear = 1'b0;
`ifdef TIMEBASE_LOAD_EN
   logic       load = 1'b0;
   logic [5:0] load_sec = '0;
   logic [5:0] load_min = '0;
`endif
   logic       tick;
   logic [5:0] sec;
   logic [5:0] min;
   logic       running;
   logic       wrap;

   timebase_counter #(
      .DIV     (DIV),
      .PW      (PW),
      .SEC_MAX (SEC_MAX),
      .MIN_MAX (MIN_MAX)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .clear    (clear),
`ifdef TIMEBASE_LOAD_EN
      .load     (load),
      .load_sec (load_sec),
      .load_min (load_min),
`endif
      .tick     (tick),
      .sec      (sec),
      .min      (min),
      .running  (running),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      int edge_n;
      int sec;
      int min;
      int wrap;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   m_sec = 0;
   int   m_min = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s = %0d (edge %0d)", name, act, cyc);
      end
   endtask

   // Expected-value model: advance min:sec by one tick and queue the result.
   task automatic push_tick(input int edge_n);
      exp_t e;
      int   wr;
      wr = 0;
      if (m_sec == SEC_MAX) begin
         m_sec = 0;
         if (m_min == MIN_MAX) begin
            m_min = 0;
            wr    = 1;
         end else begin
            m_min = m_min + 1;
         end
      end else begin
         m_sec = m_sec + 1;
      end
      e.edge_n = edge_n;
      e.sec    = m_sec;
      e.min    = m_min;
      e.wrap   = wr;
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: tick is the "output valid" of this block.
   always @(negedge clk) begin
      if (wrap && !tick) begin
         n_vec++;
         n_err++;
         $display("FAIL wrap_without_tick: wrap=1 tick=0 at edge %0d", cyc);
      end
      if (tick) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_tick: tick=1 at edge %0d, none expected", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (cyc != e.edge_n || sec != 6'(e.sec) || min != 6'(e.min) ||
                wrap != e.wrap[0]) begin
               n_err++;
               $display("FAIL tick: edge %0d sec %0d min %0d wrap %0d, expected edge %0d sec %0d min %0d wrap %0d",
                        cyc, sec, min, wrap, e.edge_n, e.sec, e.min, e.wrap);
            end else begin
               $display("tick edge %0d sec %0d min %0d wrap %0d", cyc, sec, min, wrap);
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int r;
      int s;
      int w;
      int n;

      // Reset state
      step(3);
      chk("reset_running", running, 0);
      chk("reset_sec", sec, 0);
      chk("reset_min", min, 0);
      chk("reset_tick", tick, 0);
      chk("reset_wrap", wrap, 0);
      reset = 1'b0;
      step(1);

      // Start: running rises at the start edge, ticks at +4, +8, +12
      start = 1'b1;
      step(1);
      e0 = cyc;
      start = 1'b0;
      chk("start_running", running, 1);
      push_tick(e0 + 4);
      push_tick(e0 + 8);
      push_tick(e0 + 12);
      step(15);

      // stop on the edge where the prescaler would wrap: no tick
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      chk("stop_running", running, 0);
      step(2);
      chk("pause_sec_hold", sec, 3);

      // Resume: first RUN edge produces the deferred tick
      start = 1'b1;
      step(1);
      r = cyc;
      start = 1'b0;
      chk("resume_running", running, 1);
      push_tick(r + 1);
      push_tick(r + 5);
      step(6);

      // clear together with stop and start at sec=5
      chk("pre_clear_sec", sec, 5);
      clear = 1'b1;
      stop  = 1'b1;
      start = 1'b1;
      step(1);
      clear = 1'b0;
      stop  = 1'b0;
      start = 1'b0;
      m_sec = 0;
      m_min = 0;
      chk("clear_running", running, 0);
      chk("clear_sec", sec, 0);
      chk("clear_min", min, 0);
      chk("clear_tick", tick, 0);
      step(3);
      chk("idle_after_clear", running, 0);
      chk("queue_drained_1", q.size(), 0);

      // Reset mid-RUN at sec=7
      start = 1'b1;
      step(1);
      s = cyc;
      start = 1'b0;
      for (int k = 1; k <= 7; k++) push_tick(s + 4 * k);
      step(29);
      chk("pre_reset_sec", sec, 7);
      reset = 1'b1;
      step(1);
      m_sec = 0;
      m_min = 0;
      chk("midrun_reset_sec", sec, 0);
      chk("midrun_reset_min", min, 0);
      chk("midrun_reset_running", running, 0);
      chk("midrun_reset_tick", tick, 0);
      reset = 1'b0;
      step(3);
      chk("idle_after_reset", running, 0);
      chk("idle_after_reset_sec", sec, 0);

      // Full wrap MIN_MAX:SEC_MAX -> 0:0
      start = 1'b1;
      step(1);
      w = cyc;
      start = 1'b0;
      n = (MIN_MAX + 1) * (SEC_MAX + 1);
      for (int k = 1; k <= n; k++) push_tick(w + 4 * k);
      step(4 * (SEC_MAX + 1));
      chk("minute_roll_sec", sec, 0);
      chk("minute_roll_min", min, 1);
      step(4 * (n - (SEC_MAX + 1)));
      chk("wrap_strobe", wrap, 1);
      chk("wrap_sec", sec, 0);
      chk("wrap_min", min, 0);
      step(1);
      chk("wrap_one_cycle", wrap, 0);
      stop = 1'b1;
      step(1);
      stop  = 1'b0;
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      m_sec = 0;
      m_min = 0;
      chk("queue_drained_2", q.size(), 0);

`ifdef TIMEBASE_LOAD_EN
      // Enter PAUSE, then load a value above SEC_MAX (63 is the largest
      // 6-bit value) so it saturates.
      start = 1'b1;
      step(1);
      start = 1'b0;
      stop  = 1'b1;
      step(1);
      stop  = 1'b0;
      chk("load_pause_running", running, 0);
      load     = 1'b1;
      load_sec = 6'd63;
      load_min = 6'd3;
      step(1);
      load = 1'b0;
      chk("load_sec_sat", sec, 59);
      chk("load_min", min, 3);
      m_sec = 59;
      m_min = 3;
      start = 1'b1;
      step(1);
      r = cyc;
      start = 1'b0;
      chk("load_resume_running", running, 1);
      load     = 1'b1;
      load_sec = 6'd10;
      load_min = 6'd0;
      step(1);
      load = 1'b0;
      chk("load_in_run_sec", sec, 59);
      chk("load_in_run_min", min, 3);
      push_tick(r + 4);
      step(3);
      chk("after_load_tick_sec", sec, 0);
      chk("after_load_tick_min", min, 4);
      stop = 1'b1;
      step(1);
      stop  = 1'b0;
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      chk("queue_drained_3", q.size(), 0);
`endif

      step(4);
      chk("final_queue_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
